// File: rtl/smiley_move_pkg.sv
// rtl/smiley_move_pkg.sv - shared types and constants for the smiley motion controller
package smiley_move_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    SOF,
    POS_CHANGE,
    POS_LIMITS
  } state_t;

  localparam int FP_BITS = 6;

  localparam int HIT_LEFT   = 3;
  localparam int HIT_TOP    = 2;
  localparam int HIT_RIGHT  = 1;
  localparam int HIT_BOTTOM = 0;

endpackage

// File: rtl/smiley_move_ctrl.sv
// rtl/smiley_move_ctrl.sv - per-frame bounce/gravity/jump motion for the smiley sprite
module smiley_move_ctrl
  import smiley_move_pkg::*;
#(
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int INITIAL_X_SPEED = 40,
  parameter int INITIAL_Y_SPEED = 20,
  parameter int Y_ACCEL         = 1,
  parameter int MAX_Y_SPEED     = 230,
  parameter int JUMP_SPEED      = 120,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 575,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 447
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               collision,
  input  logic [3:0]         HitEdgeCode,
  input  logic               toggleX,
  input  logic               jumpKey,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY
);

  localparam logic signed [31:0] X_INIT_FP = INITIAL_X <<< FP_BITS;
  localparam logic signed [31:0] Y_INIT_FP = INITIAL_Y <<< FP_BITS;
  localparam logic signed [31:0] X_MIN_FP  = X_MIN <<< FP_BITS;
  localparam logic signed [31:0] X_MAX_FP  = X_MAX <<< FP_BITS;
  localparam logic signed [31:0] Y_MIN_FP  = Y_MIN <<< FP_BITS;
  localparam logic signed [31:0] Y_MAX_FP  = Y_MAX <<< FP_BITS;
  localparam logic signed [15:0] Y_SPD_MAX = 16'(MAX_Y_SPEED);

  state_t             state_q, state_d;
  logic signed [31:0] xpos, ypos;
  logic signed [15:0] xspeed, yspeed;
  logic        [3:0]  hit_reg;
  logic               toggle_reg;
  logic               bounce_x, bounce_y;
  logic signed [15:0] yspeed_inc;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = MOVE;
      MOVE:       if (startOfFrame) state_d = SOF;
      SOF:        state_d = POS_CHANGE;
      POS_CHANGE: state_d = POS_LIMITS;
      POS_LIMITS: state_d = MOVE;
      default:    state_d = IDLE;
    endcase
  end

  // Only a hit that opposes the current direction bounces; stale hits are dropped.
  always_comb begin
    bounce_x   = (hit_reg[HIT_RIGHT] && (xspeed > 16'sd0)) ||
                 (hit_reg[HIT_LEFT]  && (xspeed < 16'sd0));
    bounce_y   = (hit_reg[HIT_BOTTOM] && (yspeed > 16'sd0)) ||
                 (hit_reg[HIT_TOP]    && (yspeed < 16'sd0));
    yspeed_inc = yspeed + 16'(Y_ACCEL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_reg    <= 4'b0;
      toggle_reg <= 1'b0;
      xspeed     <= 16'(INITIAL_X_SPEED);
      yspeed     <= 16'(INITIAL_Y_SPEED);
      xpos       <= X_INIT_FP;
      ypos       <= Y_INIT_FP;
    end else begin
      // SOF consumes the captured events; anything arriving that cycle waits a frame.
      hit_reg    <= ((state_q == SOF) ? 4'b0 : hit_reg) | (collision ? HitEdgeCode : 4'b0);
      toggle_reg <= ((state_q == SOF) ? 1'b0 : toggle_reg) | toggleX;
      case (state_q)
        SOF: begin
          if (bounce_x ^ toggle_reg) xspeed <= -xspeed;
          if (jumpKey)               yspeed <= -16'(JUMP_SPEED);
          else if (bounce_y)         yspeed <= -yspeed;
        end
        POS_CHANGE: begin
          xpos   <= xpos + 32'(xspeed);
          ypos   <= ypos + 32'(yspeed);
          yspeed <= (yspeed_inc > Y_SPD_MAX) ? Y_SPD_MAX : yspeed_inc;
        end
        POS_LIMITS: begin
          if (xpos < X_MIN_FP)      xpos <= X_MIN_FP;
          else if (xpos > X_MAX_FP) xpos <= X_MAX_FP;
          if (ypos < Y_MIN_FP)      ypos <= Y_MIN_FP;
          else if (ypos > Y_MAX_FP) ypos <= Y_MAX_FP;
        end
        default: ;
      endcase
    end
  end

  assign topLeftX = 11'(xpos >>> FP_BITS);
  assign topLeftY = 11'(ypos >>> FP_BITS);

endmodule

// File: tb/tb_smiley_move_ctrl.sv
// tb/tb_smiley_move_ctrl.sv - self-checking bench for smiley_move_ctrl
module tb_smiley_move_ctrl;
  import smiley_move_pkg::*;

  logic              clk = 1'b0;
  logic              reset, startOfFrame, collision, toggleX, jumpKey;
  logic [3:0]        HitEdgeCode;
  logic signed [10:0] topLeftX, topLeftY;

  smiley_move_ctrl dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .collision(collision),
    .HitEdgeCode(HitEdgeCode), .toggleX(toggleX), .jumpKey(jumpKey),
    .topLeftX(topLeftX), .topLeftY(topLeftY)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xpos; int ypos; int xs; int ys; int tx; int ty;
  } exp_t;

  typedef struct {
    logic [3:0] hit; logic tog; logic jump; exp_t e;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  exp_t   sb[$];
  vec_t   vecs[10];
  int     m_xpos, m_ypos, m_xs, m_ys;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [3:0] hit, input logic tog, input logic jump,
                         input int xp, input int yp, input int xs, input int ys,
                         input int tx, input int ty);
    vecs[i].hit  = hit;
    vecs[i].tog  = tog;
    vecs[i].jump = jump;
    vecs[i].e.xpos = xp; vecs[i].e.ypos = yp;
    vecs[i].e.xs   = xs; vecs[i].e.ys   = ys;
    vecs[i].e.tx   = tx; vecs[i].e.ty   = ty;
  endtask

  // Leaves the DUT in MOVE, just after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    m_xpos = 280 * 64; m_ypos = 185 * 64; m_xs = 40; m_ys = 20;
  endtask

  task automatic model_step(input logic [3:0] hit, input logic tog, input logic jump,
                            output exp_t e);
    logic bx;
    bx = (hit[1] && m_xs > 0) || (hit[3] && m_xs < 0);
    if (bx != tog) m_xs = -m_xs;
    if (jump) m_ys = -120;
    else if ((hit[0] && m_ys > 0) || (hit[2] && m_ys < 0)) m_ys = -m_ys;
    m_xpos += m_xs;
    m_ypos += m_ys;
    m_ys = (m_ys + 1 > 230) ? 230 : m_ys + 1;
    if (m_xpos < 0) m_xpos = 0; else if (m_xpos > 575 * 64) m_xpos = 575 * 64;
    if (m_ypos < 0) m_ypos = 0; else if (m_ypos > 447 * 64) m_ypos = 447 * 64;
    e.xpos = m_xpos; e.ypos = m_ypos; e.xs = m_xs; e.ys = m_ys;
    e.tx = m_xpos >>> 6; e.ty = m_ypos >>> 6;
  endtask

  // One frame: capture cycle in MOVE, SOF pulse, then sample after POS_LIMITS.
  task automatic do_frame(input logic [3:0] hit, input logic tog, input logic jump,
                          input exp_t e, input string tag);
    exp_t g;
    sb.push_back(e);
    collision = (hit != 4'h0); HitEdgeCode = hit; toggleX = tog;
    @(posedge clk); #1;
    collision = 1'b0; HitEdgeCode = 4'h0; toggleX = 1'b0;
    startOfFrame = 1'b1; jumpKey = jump;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    @(posedge clk); #1;
    jumpKey = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      g = sb.pop_front();
      chk({tag, "_xpos"},   int'(dut.xpos),   g.xpos);
      chk({tag, "_ypos"},   int'(dut.ypos),   g.ypos);
      chk({tag, "_xspeed"}, int'(dut.xspeed), g.xs);
      chk({tag, "_yspeed"}, int'(dut.yspeed), g.ys);
      chk({tag, "_topX"},   int'(topLeftX),   g.tx);
      chk({tag, "_topY"},   int'(topLeftY),   g.ty);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; startOfFrame = 1'b0; collision = 1'b0;
    HitEdgeCode = 4'h0; toggleX = 1'b0; jumpKey = 1'b0;

    // single-frame vectors, each from reset: X=17920 Y=11840 Xs=40 Ys=20
    set_vec(0, 4'h0, 1'b0, 1'b0, 17960, 11860,  40,   21, 280, 185);
    set_vec(1, 4'h2, 1'b0, 1'b0, 17880, 11860, -40,   21, 279, 185);
    set_vec(2, 4'h8, 1'b0, 1'b0, 17960, 11860,  40,   21, 280, 185);
    set_vec(3, 4'h6, 1'b0, 1'b0, 17880, 11860, -40,   21, 279, 185);
    set_vec(4, 4'h3, 1'b0, 1'b0, 17880, 11820, -40,  -19, 279, 184);
    set_vec(5, 4'h2, 1'b1, 1'b0, 17960, 11860,  40,   21, 280, 185);
    set_vec(6, 4'h0, 1'b1, 1'b0, 17880, 11860, -40,   21, 279, 185);
    set_vec(7, 4'h0, 1'b0, 1'b1, 17960, 11720,  40, -119, 280, 183);
    set_vec(8, 4'h1, 1'b0, 1'b1, 17960, 11720,  40, -119, 280, 183);
    set_vec(9, 4'h4, 1'b0, 1'b0, 17960, 11860,  40,   21, 280, 185);

    @(posedge clk); #1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_state",  int'(dut.state_q), int'(IDLE));
    chk("rst_topX",   int'(topLeftX), 280);
    chk("rst_topY",   int'(topLeftY), 185);
    chk("rst_xspeed", int'(dut.xspeed), 40);
    chk("rst_yspeed", int'(dut.yspeed), 20);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      do_frame(vecs[i].hit, vecs[i].tog, vecs[i].jump, vecs[i].e, $sformatf("vec%0d", i));
    end

    // two consecutive quiet frames
    do_reset();
    do_frame(4'h0, 1'b0, 1'b0, vecs[0].e, "f1");
    e.xpos = 18000; e.ypos = 11881; e.xs = 40; e.ys = 22; e.tx = 281; e.ty = 185;
    do_frame(4'h0, 1'b0, 1'b0, e, "f2");

    // reset lands during POS_CHANGE with a right hit pending
    do_reset();
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0; collision = 1'b1; HitEdgeCode = 4'h2;
    @(posedge clk); #1;
    collision = 1'b0; HitEdgeCode = 4'h0;
    chk("mid_state_poschange", int'(dut.state_q), int'(POS_CHANGE));
    chk("mid_hit_pending",     int'(dut.hit_reg), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_state",  int'(dut.state_q), int'(IDLE));
    chk("mid_rst_topX",   int'(topLeftX), 280);
    chk("mid_rst_topY",   int'(topLeftY), 185);
    chk("mid_rst_xspeed", int'(dut.xspeed), 40);
    chk("mid_rst_hit",    int'(dut.hit_reg), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    do_frame(4'h0, 1'b0, 1'b0, vecs[0].e, "post_rst");

    // long free run: X clamps at 575, Yspeed saturates at 230, Y clamps at 447
    do_reset();
    for (int n = 0; n < 480; n++) begin
      model_step(4'h0, 1'b0, 1'b0, e);
      do_frame(4'h0, 1'b0, 1'b0, e, $sformatf("run%0d", n));
      chk("x_within_max", (topLeftX <= 11'sd575) ? 1 : 0, 1);
    end
    chk("sat_topX",   int'(topLeftX), 575);
    chk("sat_topY",   int'(topLeftY), 447);
    chk("sat_yspeed", int'(dut.yspeed), 230);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
